// File: rtl/jstk_spi_responder_pkg.sv
// Shared constants, FSM state type and TX byte packing for the PmodJSTK SPI responder.
// Optional build macro used by the responder: JSTK_RESP_CMD_CHECK_EN.
package jstk_pkg;

    localparam int unsigned JSTK_NUM_BYTES  = 5;
    localparam int unsigned JSTK_TX_BITS    = 8 * JSTK_NUM_BYTES;
    localparam logic [5:0]  JSTK_CMD_PREFIX = 6'b100000;

    localparam int unsigned JSTK_POS_PAD = 6;
    localparam int unsigned JSTK_BTN_PAD = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_OVERRUN = 2'd2
    } jstk_state_e;

    // Byte 0 sits in the low byte so the shifter always transmits bits [7:0].
    function automatic logic [JSTK_TX_BITS-1:0] jstk_pack_tx(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] btn
    );
        return {{JSTK_BTN_PAD{1'b0}}, btn,
                {JSTK_POS_PAD{1'b0}}, y[9:8],
                y[7:0],
                {JSTK_POS_PAD{1'b0}}, x[9:8],
                x[7:0]};
    endfunction

endpackage

// File: rtl/jstk_spi_responder_if.sv
// SPI pin bundle between a master and the joystick responder.
interface jstk_spi_responder_if;

    logic cs;
    logic sck;
    logic mosi;
    logic miso;

    modport master (
        output cs,
        output sck,
        output mosi,
        input  miso
    );

    modport slave (
        input  cs,
        input  sck,
        input  mosi,
        output miso
    );

endinterface

// File: rtl/jstk_spi_responder_sync_edge.sv
// Multi-flop synchronizer with level, rise/fall pulses and a post-reset valid flag.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_valid
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_valid;
    logic                   r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= {SYNC_STAGES{RESET_VAL}};
            r_prev  <= RESET_VAL;
            r_valid <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev  <= r_sync[SYNC_STAGES-1];
            r_valid <= {r_valid[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // o_valid marks when o_level reflects a real pin sample rather than the reset fill.
    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_prev;
    assign o_fall  = ~o_level & r_prev;
    assign o_valid = r_valid[SYNC_STAGES-1];

endmodule

// File: rtl/jstk_spi_responder.sv
// PmodJSTK-compatible SPI mode-0 slave: reports X/Y/buttons, captures the LED command.
// Build option: define JSTK_RESP_CMD_CHECK_EN to require the 6'b100000 command prefix.
module jstk_spi_responder
    import jstk_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_BYTES   = JSTK_NUM_BYTES
) (
    input  logic                 clk50M,
    input  logic                 reset,
    jstk_spi_responder_if.slave  spi,
    input  logic [9:0]           x_pos,
    input  logic [9:0]           y_pos,
    input  logic [2:0]           buttons,
    output logic [1:0]           led_cmd,
    output logic                 xfer_done,
    output logic                 frame_error
);

    localparam int unsigned BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);

    logic w_cs_level, w_cs_rise, w_cs_fall, w_cs_valid;
    logic w_sck_level, w_sck_rise, w_sck_fall, w_sck_valid;
    logic w_mosi_level, w_mosi_rise, w_mosi_fall, w_mosi_valid;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .i_clk   (clk50M),
        .i_rst   (reset),
        .i_async (spi.cs),
        .o_level (w_cs_level),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall),
        .o_valid (w_cs_valid)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .i_clk   (clk50M),
        .i_rst   (reset),
        .i_async (spi.sck),
        .o_level (w_sck_level),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall),
        .o_valid (w_sck_valid)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .i_clk   (clk50M),
        .i_rst   (reset),
        .i_async (spi.mosi),
        .o_level (w_mosi_level),
        .o_rise  (w_mosi_rise),
        .o_fall  (w_mosi_fall),
        .o_valid (w_mosi_valid)
    );

    jstk_state_e              r_state, w_state_nxt;
    logic                     r_cs_armed;
    logic [JSTK_TX_BITS-1:0]  r_tx_snap;
    logic [2:0]               r_bit_cnt;
    logic [BYTE_W-1:0]        r_byte_cnt;
    logic [6:0]               r_rx_sr;
    logic [7:0]               r_rx0;
    logic                     r_overrun;
    logic                     r_miso;
    logic [1:0]               r_led;
    logic                     r_xfer_done;
    logic                     r_frame_error;

    logic                     w_start;
    logic                     w_xfer_nxt;
    logic                     w_ferr_nxt;
    logic                     w_byte_end;
    logic                     w_cmd_ok;
    logic [2:0]               w_bit_idx;
    logic [7:0]               w_tx_byte;
    logic [JSTK_TX_BITS-1:0]  w_tx_load;

    assign w_byte_end = (r_bit_cnt == 3'd7);
    assign w_bit_idx  = 3'd7 - r_bit_cnt;
    assign w_tx_byte  = r_tx_snap[7:0];
    assign w_tx_load  = jstk_pack_tx(x_pos, y_pos, buttons);

`ifdef JSTK_RESP_CMD_CHECK_EN
    assign w_cmd_ok = (r_rx0[7:2] == JSTK_CMD_PREFIX);
`else
    assign w_cmd_ok = 1'b1;
`endif

    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // cs rise is checked first in every state, so a coincident sck edge is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_xfer_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_cs_fall && r_cs_armed) begin
                    w_state_nxt = ST_ACTIVE;
                    w_start     = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_ferr_nxt  = 1'b1;
                end else if (w_sck_rise && w_byte_end && (r_byte_cnt == LAST_BYTE)) begin
                    w_state_nxt = ST_OVERRUN;
                end
            end
            ST_OVERRUN: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_xfer_nxt  = ~r_overrun;
                    w_ferr_nxt  = r_overrun;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A cs falling edge only counts once cs has been seen high after reset.
    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            r_cs_armed <= 1'b0;
            r_tx_snap  <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_rx_sr    <= '0;
            r_rx0      <= '0;
            r_overrun  <= 1'b0;
            r_miso     <= 1'b0;
        end else begin
            r_cs_armed <= r_cs_armed | (w_cs_valid & w_cs_level);
            unique case (r_state)
                ST_IDLE: begin
                    r_miso <= 1'b0;
                    if (w_start) begin
                        r_tx_snap  <= w_tx_load;
                        r_miso     <= w_tx_load[7];
                        r_bit_cnt  <= '0;
                        r_byte_cnt <= '0;
                        r_rx_sr    <= '0;
                        r_overrun  <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_cs_rise) begin
                        r_miso <= 1'b0;
                    end else if (w_sck_rise) begin
                        r_rx_sr   <= {r_rx_sr[5:0], w_mosi_level};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_byte_end) begin
                            if (r_byte_cnt == '0) r_rx0 <= {r_rx_sr, w_mosi_level};
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            r_tx_snap  <= r_tx_snap >> 8;
                            if (r_byte_cnt == LAST_BYTE) r_miso <= 1'b0;
                        end
                    end else if (w_sck_fall) begin
                        r_miso <= w_tx_byte[w_bit_idx];
                    end
                end
                ST_OVERRUN: begin
                    r_miso <= 1'b0;
                    if (!w_cs_rise && w_sck_rise) r_overrun <= 1'b1;
                end
                default: r_miso <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            r_led         <= 2'b00;
            r_xfer_done   <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_xfer_done   <= w_xfer_nxt;
            r_frame_error <= w_ferr_nxt;
            if (w_xfer_nxt && w_cmd_ok) r_led <= r_rx0[1:0];
        end
    end

    assign spi.miso    = r_miso;
    assign led_cmd     = r_led;
    assign xfer_done   = r_xfer_done;
    assign frame_error = r_frame_error;

    logic w_unused;
    assign w_unused = &{1'b0, w_sck_level, w_sck_valid, w_mosi_rise, w_mosi_fall,
                        w_mosi_valid, r_rx0[7:2]};

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench for jstk_spi_responder: 1 MHz mode-0 master, expected bytes hand-computed.
module tb_jstk_spi_responder;

    localparam int HALF = 25;

    logic       clk50M = 1'b0;
    logic       reset;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [2:0] buttons;
    logic [1:0] led_cmd;
    logic       xfer_done;
    logic       frame_error;

    int n_chk  = 0;
    int n_pass = 0;
    int n_xfer = 0;
    int n_ferr = 0;
    int base_x = 0;
    int base_f = 0;

    logic [7:0] rx;
    logic [1:0] exp_led_cmd3;

    jstk_spi_responder_if spi_if ();

    jstk_spi_responder #(.SYNC_STAGES(2), .NUM_BYTES(5)) dut (
        .clk50M      (clk50M),
        .reset       (reset),
        .spi         (spi_if),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .buttons     (buttons),
        .led_cmd     (led_cmd),
        .xfer_done   (xfer_done),
        .frame_error (frame_error)
    );

    always #10 clk50M = ~clk50M;

    always @(negedge clk50M) begin
        if (xfer_done === 1'b1)   n_xfer++;
        if (frame_error === 1'b1) n_ferr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rxb);
        rxb = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_if.mosi = tx[7-i];
            repeat (HALF) @(negedge clk50M);
            rxb[7-i] = spi_if.miso;
            spi_if.sck = 1'b1;
            repeat (HALF) @(negedge clk50M);
            spi_if.sck = 1'b0;
        end
    endtask

    task automatic cs_start();
        base_x = n_xfer;
        base_f = n_ferr;
        spi_if.cs = 1'b0;
        repeat (HALF) @(negedge clk50M);
    endtask

    task automatic cs_end(input string tag, input logic exp_x, input logic exp_f,
                          input logic [1:0] exp_led);
        repeat (HALF) @(negedge clk50M);
        spi_if.cs = 1'b1;
        repeat (2) @(negedge clk50M);
        check({tag, ".early"}, {30'd0, xfer_done, frame_error}, 32'd0);
        @(negedge clk50M);
        check({tag, ".xfer_done"},   {31'd0, xfer_done},   {31'd0, exp_x});
        check({tag, ".frame_error"}, {31'd0, frame_error}, {31'd0, exp_f});
        check({tag, ".led_cmd"},     {30'd0, led_cmd},     {30'd0, exp_led});
        check({tag, ".miso_idle"},   {31'd0, spi_if.miso}, 32'd0);
        @(negedge clk50M);
        check({tag, ".late"}, {30'd0, xfer_done, frame_error}, 32'd0);
        check({tag, ".n_xfer"}, n_xfer - base_x, {31'd0, exp_x});
        check({tag, ".n_ferr"}, n_ferr - base_f, {31'd0, exp_f});
        repeat (HALF) @(negedge clk50M);
    endtask

    task automatic run_xfer(input string tag, input logic [7:0] cmd, input int nbytes,
                            input logic [47:0] exp_bytes, input logic exp_x,
                            input logic exp_f, input logic [1:0] exp_led);
        logic [7:0] rxb;
        cs_start();
        for (int b = 0; b < nbytes; b++) begin
            spi_bits((b == 0) ? cmd : 8'h00, 8, rxb);
            check($sformatf("%s.byte%0d", tag, b), {24'd0, rxb}, {24'd0, exp_bytes[8*b +: 8]});
        end
        cs_end(tag, exp_x, exp_f, exp_led);
    endtask

    initial begin
        reset       = 1'b1;
        spi_if.cs   = 1'b1;
        spi_if.sck  = 1'b0;
        spi_if.mosi = 1'b0;
        x_pos       = 10'd300;
        y_pos       = 10'd511;
        buttons     = 3'b101;

        repeat (4) @(negedge clk50M);
        check("reset.miso",        {31'd0, spi_if.miso}, 32'd0);
        check("reset.led_cmd",     {30'd0, led_cmd},     32'd0);
        check("reset.xfer_done",   {31'd0, xfer_done},   32'd0);
        check("reset.frame_error", {31'd0, frame_error}, 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk50M);

        // Nominal: x=300 -> 2C,01; y=511 -> FF,01; buttons -> 05; cmd 0x83 -> led 11
        run_xfer("nominal", 8'h83, 5, 48'h00_05_01_FF_01_2C, 1'b1, 1'b0, 2'b11);

        // Coherency: x changes after byte 0, snapshot must hold
        cs_start();
        spi_bits(8'h82, 8, rx);
        check("coh.byte0", {24'd0, rx}, 32'h2C);
        x_pos = 10'd10;
        spi_bits(8'h00, 8, rx);
        check("coh.byte1", {24'd0, rx}, 32'h01);
        spi_bits(8'h00, 8, rx);
        check("coh.byte2", {24'd0, rx}, 32'hFF);
        spi_bits(8'h00, 8, rx);
        check("coh.byte3", {24'd0, rx}, 32'h01);
        spi_bits(8'h00, 8, rx);
        check("coh.byte4", {24'd0, rx}, 32'h05);
        cs_end("coh", 1'b1, 1'b0, 2'b10);

        run_xfer("coh_next", 8'h81, 5, 48'h00_05_01_FF_00_0A, 1'b1, 1'b0, 2'b01);

        // Abort after 12 sck cycles
        cs_start();
        spi_bits(8'h82, 8, rx);
        check("abort.byte0", {24'd0, rx}, 32'h0A);
        spi_bits(8'h00, 4, rx);
        cs_end("abort", 1'b0, 1'b1, 2'b01);

        // Overrun: sixth byte reads zero, frame_error at cs rise
        run_xfer("overrun", 8'h82, 6, 48'h00_05_01_FF_00_0A, 1'b0, 1'b1, 2'b01);

        // Reset with cs low in the middle of byte 2
        cs_start();
        spi_bits(8'h82, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 3, rx);
        reset = 1'b1;
        repeat (3) @(negedge clk50M);
        check("rstmid.miso",    {31'd0, spi_if.miso}, 32'd0);
        check("rstmid.led_cmd", {30'd0, led_cmd},     32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk50M);
        spi_bits(8'hFF, 8, rx);
        check("rstmid.miso_byte", {24'd0, rx}, 32'd0);
        spi_bits(8'hFF, 2, rx);
        check("rstmid.miso_bits", {24'd0, rx}, 32'd0);
        cs_end("rstmid", 1'b0, 1'b0, 2'b00);

        run_xfer("recover", 8'h82, 5, 48'h00_05_01_FF_00_0A, 1'b1, 1'b0, 2'b10);

        // Command without the 100000 prefix
`ifdef JSTK_RESP_CMD_CHECK_EN
        exp_led_cmd3 = 2'b10;
`else
        exp_led_cmd3 = 2'b11;
`endif
        buttons = 3'b010;
        y_pos   = 10'd0;
        run_xfer("cmd03", 8'h03, 5, 48'h00_02_00_00_00_0A, 1'b1, 1'b0, exp_led_cmd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
